// File: rtl/membus_arbiter_pkg.sv
// membus_arbiter_pkg: master ids, arbitration state encoding and bus command layout
// shared by the arbiter and its read-return pipeline.
package membus_arbiter_pkg;

    localparam logic MASTER_CPU = 1'b0;
    localparam logic MASTER_AUX = 1'b1;

    localparam int BUS_ADDR_W = 32;
    localparam int BUS_DATA_W = 32;

    typedef enum logic {ARB_RR, ARB_LOCKED} arb_state_e;

    typedef struct packed {
        logic                  we;
        logic [BUS_ADDR_W-1:0] addr;
        logic [BUS_DATA_W-1:0] wdata;
    } bus_cmd_t;

endpackage

// File: rtl/membus_rd_return.sv
// membus_rd_return: (valid, id) shift pipeline matching the device read latency,
// steering returning read data to the master that issued the read.
module membus_rd_return
    import membus_arbiter_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              rd_i,
    input  logic              id_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic              m0_rvalid_o,
    output logic              m1_rvalid_o,
    output logic [DATA_W-1:0] m0_rdata_o,
    output logic [DATA_W-1:0] m1_rdata_o
);

    logic              tail_v;
    logic              tail_id;
    logic [DATA_W-1:0] hold0_q;
    logic [DATA_W-1:0] hold1_q;

    generate
        if (READ_LAT == 0) begin : g_comb
            assign tail_v  = rd_i;
            assign tail_id = id_i;
        end else begin : g_pipe
            logic [READ_LAT-1:0] vld_q;
            logic [READ_LAT-1:0] id_q;
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    vld_q <= '0;
                    id_q  <= '0;
                end else begin
                    vld_q <= (vld_q << 1) | READ_LAT'(rd_i);
                    id_q  <= (id_q << 1) | READ_LAT'(id_i);
                end
            end
            assign tail_v  = vld_q[READ_LAT-1];
            assign tail_id = id_q[READ_LAT-1];
        end
    endgenerate

    // The idle master's rdata keeps showing its last returned word.
    always_comb begin
        m0_rvalid_o = tail_v && tail_id == MASTER_CPU;
        m1_rvalid_o = tail_v && tail_id == MASTER_AUX;
        m0_rdata_o  = m0_rvalid_o ? rdata_i : hold0_q;
        m1_rdata_o  = m1_rvalid_o ? rdata_i : hold1_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold0_q <= '0;
            hold1_q <= '0;
        end else begin
            hold0_q <= m0_rdata_o;
            hold1_q <= m1_rdata_o;
        end
    end

endmodule

// File: rtl/membus_arbiter.sv
// membus_arbiter: two-master round-robin arbiter with bounded bus lock, registering
// the winning command onto the device bus and routing read data back.
module membus_arbiter
    import membus_arbiter_pkg::*;
#(
    parameter int ADDR_W   = BUS_ADDR_W,
    parameter int DATA_W   = BUS_DATA_W,
    parameter int READ_LAT = 1,
    parameter int LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              Device_Read,
    output logic              Device_Write,
    output logic [ADDR_W-1:0] MemBus_Address,
    output logic [DATA_W-1:0] MemBus_Write_Data,
    input  logic [DATA_W-1:0] Device_Read_Data
);

    localparam int CW = $clog2(LOCK_MAX + 1);

    arb_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
    logic              lk, acc, win, win_lock, stay, enter;
    bus_cmd_t          cmd;
    logic              dev_rd_q, dev_wr_q, id_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    always_comb begin
        lk       = state_q == ARB_LOCKED;
        m0_gnt   = reset && m0_req && (lk ? owner_q == MASTER_CPU : (!m1_req || last_q == MASTER_AUX));
        m1_gnt   = reset && m1_req && (lk ? owner_q == MASTER_AUX : (!m0_req || last_q == MASTER_CPU));
        acc      = m0_gnt || m1_gnt;
        win      = m1_gnt ? MASTER_AUX : MASTER_CPU;
        cmd      = m1_gnt ? bus_cmd_t'{we: m1_we, addr: m1_addr, wdata: m1_wdata}
                          : bus_cmd_t'{we: m0_we, addr: m0_addr, wdata: m0_wdata};
        win_lock = m1_gnt ? m1_lock : m0_lock;
        cnt_inc  = cnt_q + 1'b1;
        // The accept that makes the count reach LOCK_MAX-1 is the owner's last one.
        stay     = acc && win_lock && cnt_inc < CW'(LOCK_MAX - 1);
        enter    = acc && win_lock && LOCK_MAX > 1;
        state_d  = lk ? (stay ? ARB_LOCKED : ARB_RR) : (enter ? ARB_LOCKED : ARB_RR);
        owner_d  = lk ? owner_q : win;
        cnt_d    = (lk && stay) ? cnt_inc : '0;
        last_d   = acc ? win : last_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ARB_RR;
            owner_q  <= MASTER_CPU;
            last_q   <= MASTER_AUX;
            cnt_q    <= '0;
            dev_rd_q <= 1'b0;
            dev_wr_q <= 1'b0;
            id_q     <= MASTER_CPU;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            dev_rd_q <= acc && !cmd.we;
            dev_wr_q <= acc && cmd.we;
            if (acc) begin
                id_q    <= win;
                addr_q  <= cmd.addr;
                wdata_q <= cmd.wdata;
            end
        end
    end

    assign Device_Read       = dev_rd_q;
    assign Device_Write      = dev_wr_q;
    assign MemBus_Address    = addr_q;
    assign MemBus_Write_Data = wdata_q;

    membus_rd_return #(
        .DATA_W  (DATA_W),
        .READ_LAT(READ_LAT)
    ) u_rd_return (
        .clk_i      (clk),
        .rst_ni     (reset),
        .rd_i       (dev_rd_q),
        .id_i       (id_q),
        .rdata_i    (Device_Read_Data),
        .m0_rvalid_o(m0_rvalid),
        .m1_rvalid_o(m1_rvalid),
        .m0_rdata_o (m0_rdata),
        .m1_rdata_o (m1_rdata)
    );

endmodule

// File: tb/tb_membus_arbiter.sv
// tb_membus_arbiter: four arbiters (READ_LAT 1,0,3,2) share one stimulus stream;
// directed vectors with hand-computed grants, strobes and read returns.
module tb_membus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;

    logic        gnt0 [4], gnt1 [4], rv0 [4], rv1 [4], drd [4], dwr [4];
    logic [31:0] rd0 [4], rd1 [4], baddr [4], bwd [4], dev_rdata [4];

    int n_chk = 0;
    int n_err = 0;
    int cnt [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int L = g == 0 ? 1 : g == 1 ? 0 : g == 2 ? 3 : 2;
        logic [31:0] ap [3];
        // Device model: returns the read address as data, READ_LAT cycles later.
        always @(posedge clk) begin
            ap[0] <= baddr[g];
            ap[1] <= ap[0];
            ap[2] <= ap[1];
        end
        assign dev_rdata[g] = L == 0 ? baddr[g] : ap[L == 0 ? 0 : L - 1];
        membus_arbiter #(
            .ADDR_W  (32),
            .DATA_W  (32),
            .READ_LAT(L),
            .LOCK_MAX(16)
        ) u_dut (
            .clk              (clk),
            .reset            (reset),
            .m0_req           (m0_req),
            .m0_we            (m0_we),
            .m0_lock          (m0_lock),
            .m0_addr          (m0_addr),
            .m0_wdata         (m0_wdata),
            .m0_gnt           (gnt0[g]),
            .m0_rvalid        (rv0[g]),
            .m0_rdata         (rd0[g]),
            .m1_req           (m1_req),
            .m1_we            (m1_we),
            .m1_lock          (m1_lock),
            .m1_addr          (m1_addr),
            .m1_wdata         (m1_wdata),
            .m1_gnt           (gnt1[g]),
            .m1_rvalid        (rv1[g]),
            .m1_rdata         (rd1[g]),
            .Device_Read      (drd[g]),
            .Device_Write     (dwr[g]),
            .MemBus_Address   (baddr[g]),
            .MemBus_Write_Data(bwd[g]),
            .Device_Read_Data (dev_rdata[g])
        );
    end

    function automatic int lat(input int g);
        return g == 0 ? 1 : g == 1 ? 0 : g == 2 ? 3 : 2;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        m0_req  = 1'b0;
        m0_we   = 1'b0;
        m0_lock = 1'b0;
        m1_req  = 1'b0;
        m1_we   = 1'b0;
        m1_lock = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        idle();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset    = 1'b0;
        idle();
        m0_addr  = '0;
        m0_wdata = '0;
        m1_addr  = '0;
        m1_wdata = '0;
        m0_req   = 1'b1;
        m1_req   = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        for (int g = 0; g < 4; g++) begin
            check($sformatf("rst.g%0d.m0_gnt", g), gnt0[g], 0);
            check($sformatf("rst.g%0d.m1_gnt", g), gnt1[g], 0);
            check($sformatf("rst.g%0d.Device_Read", g), drd[g], 0);
            check($sformatf("rst.g%0d.Device_Write", g), dwr[g], 0);
            check($sformatf("rst.g%0d.MemBus_Address", g), baddr[g], 0);
            check($sformatf("rst.g%0d.rvalid", g), {rv1[g], rv0[g]}, 0);
            check($sformatf("rst.g%0d.m0_rdata", g), rd0[g], 0);
        end
        idle();
        @(negedge clk);
        reset = 1'b1;

        // Single master write.
        m0_req   = 1'b1;
        m0_we    = 1'b1;
        m0_addr  = 32'h4000_0010;
        m0_wdata = 32'h0000_00AB;
        #1;
        check("wr.m0_gnt", gnt0[0], 1);
        check("wr.m1_gnt", gnt1[0], 0);
        @(negedge clk);
        m0_req = 1'b0;
        #1;
        check("wr.m0_gnt_off", gnt0[0], 0);
        check("wr.Device_Write", dwr[0], 1);
        check("wr.Device_Read", drd[0], 0);
        check("wr.MemBus_Address", baddr[0], 32'h4000_0010);
        check("wr.MemBus_Write_Data", bwd[0], 32'h0000_00AB);
        @(negedge clk);
        #1;
        check("wr.Device_Write_idle", dwr[0], 0);
        check("wr.MemBus_Address_hold", baddr[0], 32'h4000_0010);

        // Contention: eight alternating reads from reset, then drain.
        do_reset();
        for (int g = 0; g < 4; g++) cnt[g] = 0;
        for (int i = 0; i < 13; i++) begin
            m0_req  = i < 8;
            m1_req  = i < 8;
            m0_we   = 1'b0;
            m1_we   = 1'b0;
            m0_addr = 32'h11;
            m1_addr = 32'h22;
            #1;
            check($sformatf("cont%0d.m0_gnt", i), gnt0[0], i < 8 && i % 2 == 0);
            check($sformatf("cont%0d.m1_gnt", i), gnt1[0], i < 8 && i % 2 == 1);
            check($sformatf("cont%0d.Device_Read", i), drd[0], i >= 1 && i <= 8);
            check($sformatf("cont%0d.MemBus_Address", i), baddr[0],
                  i == 0 ? 32'h0 : (((i > 8 ? 8 : i) - 1) % 2 == 1 ? 32'h22 : 32'h11));
            for (int g = 0; g < 4; g++) begin
                int  j;
                logic v;
                j = i - lat(g) - 1;
                v = j >= 0 && j < 8;
                check($sformatf("cont%0d.g%0d.m0_rvalid", i, g), rv0[g], v && j % 2 == 0);
                check($sformatf("cont%0d.g%0d.m1_rvalid", i, g), rv1[g], v && j % 2 == 1);
                if (v) begin
                    check($sformatf("cont%0d.g%0d.rdata", i, g), j % 2 == 1 ? rd1[g] : rd0[g],
                          j % 2 == 1 ? 32'h22 : 32'h11);
                    if (j > 0)
                        check($sformatf("cont%0d.g%0d.hold", i, g), j % 2 == 1 ? rd0[g] : rd1[g],
                              j % 2 == 1 ? 32'h11 : 32'h22);
                end
                cnt[g] += int'(rv0[g]) + int'(rv1[g]);
            end
            @(negedge clk);
        end
        for (int g = 0; g < 4; g++) check($sformatf("cont.g%0d.rvalid_count", g), cnt[g], 8);

        // Lock held by m1 with m0 waiting: forced release after 16 grants.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            m1_req  = 1'b1;
            m1_lock = 1'b1;
            m1_we   = 1'b1;
            m0_req  = i > 0;
            m0_we   = 1'b1;
            m0_lock = 1'b0;
            #1;
            check($sformatf("lock%0d.m1_gnt", i), gnt1[0], i != 16);
            check($sformatf("lock%0d.m0_gnt", i), gnt0[0], i == 16);
            @(negedge clk);
        end

        // m0 locks for three accepts, then drops lock: m1 follows its last grant.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            m0_req  = 1'b1;
            m0_lock = i < 3;
            m0_we   = 1'b1;
            m1_req  = 1'b1;
            m1_lock = 1'b0;
            m1_we   = 1'b1;
            #1;
            check($sformatf("rel%0d.m0_gnt", i), gnt0[0], i < 4);
            check($sformatf("rel%0d.m1_gnt", i), gnt1[0], i == 4);
            @(negedge clk);
        end

        // Reset while a READ_LAT=2 read is in flight.
        do_reset();
        m0_req  = 1'b1;
        m0_we   = 1'b0;
        m0_addr = 32'h11;
        #1;
        check("rmid.m0_gnt", gnt0[3], 1);
        @(negedge clk);
        idle();
        #1;
        check("rmid.Device_Read", drd[3], 1);
        @(negedge clk);
        #1;
        check("rmid.lat1_rvalid", rv0[0], 1);
        check("rmid.lat2_pending", rv0[3], 0);
        reset = 1'b0;
        #1;
        check("rmid.rst_Device_Read", drd[3], 0);
        check("rmid.rst_MemBus_Address", baddr[3], 0);
        check("rmid.rst_m0_rvalid", rv0[3], 0);
        check("rmid.rst_lat1_rvalid", rv0[0], 0);
        check("rmid.rst_m0_rdata", rd0[3], 0);
        check("rmid.rst_m1_rdata", rd1[3], 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            for (int g = 0; g < 4; g++)
                check($sformatf("rmid%0d.g%0d.rvalid", i, g), {rv1[g], rv0[g]}, 0);
            check($sformatf("rmid%0d.m0_rdata", i), rd0[3], 0);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
